// File: rtl/ifu_if.sv
// Fetch-unit bundle: instruction-memory request/response channel, decoder
// output channel, execute-stage redirect and halt/halted status.
//   master : the fetch unit (drives request, decoder output and halted)
//   slave  : the environment (memory, decoder, execute stage)
interface ifu_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt;
    logic            halted;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        output out_valid, out_inst, out_pc,
        input  out_ready,
        input  redirect_valid, redirect_pc,
        input  halt,
        output halted
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        input  out_valid, out_inst, out_pc,
        output out_ready,
        output redirect_valid, redirect_pc,
        output halt,
        input  halted
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding memory request at a time, a single
// instruction holding register towards the decoder, redirect handling with
// discard of an owed response, and a sticky halt on a consumed ebreak.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ifu_if.master (imem request/response, decoder output,
//           redirect, halt/halted)
// All outputs are registered: valid flags are decoded from the next state.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic  clk,
    input  logic  rst_n,
    ifu_if.master bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned SW   = 3;

    localparam logic [SW-1:0] S_REQ    = 3'd0;
    localparam logic [SW-1:0] S_WAIT   = 3'd1;
    localparam logic [SW-1:0] S_HOLD   = 3'd2;
    localparam logic [SW-1:0] S_DROP   = 3'd3;
    localparam logic [SW-1:0] S_HALTED = 3'd4;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;

    logic [SW-1:0]   state;
    logic [SW-1:0]   state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_q_nxt;
    logic            req_valid_q;
    logic            out_valid_q;
    logic            halted_q;

    logic            req_fire_c;
    logic            out_fire_c;
    logic [XLEN-1:0] redirect_target_c;

    // Handshakes are qualified by the registered valids only.
    assign req_fire_c        = (state == S_REQ)  && req_valid_q && bus.imem_req_ready;
    assign out_fire_c        = (state == S_HOLD) && out_valid_q && bus.out_ready;
    assign redirect_target_c = bus.redirect_pc & ALIGN_MASK;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= PC_INIT;
            inst_q      <= '0;
            pc_q        <= '0;
            req_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            inst_q      <= inst_nxt;
            pc_q        <= pc_q_nxt;
            req_valid_q <= (state_nxt == S_REQ);
            out_valid_q <= (state_nxt == S_HOLD);
            halted_q    <= (state_nxt == S_HALTED);
        end
    end

    // Next-state and datapath update. Redirect outranks every other event;
    // a redirect that leaves a response owed parks in DROP to swallow it.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        inst_nxt  = inst_q;
        pc_q_nxt  = pc_q;

        case (state)
            S_REQ: begin
                if (bus.redirect_valid) begin
                    pc_nxt    = redirect_target_c;
                    state_nxt = req_fire_c ? S_DROP : S_REQ;
                end else if (req_fire_c) begin
                    state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_nxt    = redirect_target_c;
                    state_nxt = bus.imem_rsp_valid ? S_REQ : S_DROP;
                end else if (bus.imem_rsp_valid) begin
                    inst_nxt  = bus.imem_rsp_data;
                    pc_q_nxt  = pc;
                    state_nxt = S_HOLD;
                end
            end

            S_HOLD: begin
                if (bus.redirect_valid) begin
                    pc_nxt    = redirect_target_c;
                    state_nxt = S_REQ;
                end else if (out_fire_c) begin
                    pc_nxt    = pc_q + PC_STEP;
                    state_nxt = bus.halt ? S_HALTED : S_REQ;
                end
            end

            S_DROP: begin
                if (bus.redirect_valid) begin
                    pc_nxt = redirect_target_c;
                end
                if (bus.imem_rsp_valid) begin
                    state_nxt = S_REQ;
                end
            end

            S_HALTED: begin
                state_nxt = S_HALTED;
            end

            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_inst       = inst_q;
    assign bus.out_pc         = pc_q;
    assign bus.halted         = halted_q;

    // Structural invariants of the fetch protocol.
    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        req_valid_q |-> (pc[1:0] == 2'b00));
    a_req_out_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(req_valid_q && out_valid_q));
    a_halted_sticky: assert property (@(posedge clk) disable iff (!rst_n)
        halted_q |=> halted_q);
endmodule
